// File: rtl/mul_writeback_unit_pkg.sv
// Shared definitions for the multiply/writeback unit: FSM state encoding
// and the index of the hard-wired zero register.
package mul_defs;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;

   // Same register the register file treats as X31 (reads zero, ignores writes).
   localparam int ZERO_REG = 31;

endpackage

// File: rtl/mul_writeback_unit_shift_add_datapath.sv
// Shift-add multiplier datapath: one partial product per step, multiplicand
// shifts left, multiplier shifts right, accumulator wraps modulo 2^n.
module shift_add_datapath #(
   parameter int n = 64
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load,
   input  logic         step,
   input  logic [n-1:0] operand_a,
   input  logic [n-1:0] operand_b,
   output logic [n-1:0] acc
);

   logic [n-1:0] a_reg;
   logic [n-1:0] b_reg;

   // Load operands on accept, then add-and-shift once per step.
   always_ff @(posedge clock) begin
      if (reset) begin
         a_reg <= '0;
         b_reg <= '0;
         acc   <= '0;
      end else if (load) begin
         a_reg <= operand_a;
         b_reg <= operand_b;
         acc   <= '0;
      end else if (step) begin
         if (b_reg[0]) begin
            acc <= acc + a_reg;
         end
         a_reg <= a_reg << 1;
         b_reg <= b_reg >> 1;
      end
   end

endmodule

// File: rtl/mul_writeback_unit.sv
// MUL execution unit: sequences the shift-add datapath for n steps, then
// issues a single-cycle register file write of the low n product bits.
module mul_writeback_unit
   import mul_defs::*;
#(
   parameter int n          = 64,
   parameter int addr_width = 5,
   parameter int zero_reg   = ZERO_REG
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [n-1:0]          operand_a,
   input  logic [n-1:0]          operand_b,
   input  logic [addr_width-1:0] dest,
   output logic                  busy,
   output logic                  done,
   output logic [n-1:0]          result,
   output logic [addr_width-1:0] wb_address,
   output logic                  wb_write
);

   localparam int                  CW       = $clog2(n) + 1;
   localparam logic [CW-1:0]       CNT_LAST = CW'(n - 1);
   localparam logic [addr_width-1:0] ZR     = addr_width'(zero_reg);

   logic [1:0]            state;
   logic [1:0]            state_next;
   logic [CW-1:0]         count;
   logic [addr_width-1:0] dest_reg;
   logic [n-1:0]          result_hold;
   logic [addr_width-1:0] addr_hold;
   logic [n-1:0]          acc;
   logic                  load;
   logic                  step;

   shift_add_datapath #(.n(n)) u_datapath (
      .clock     (clock),
      .reset     (reset),
      .load      (load),
      .step      (step),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .acc       (acc)
   );

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: accept in IDLE, n steps in RUN, one WRITE cycle.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (start) state_next = S_RUN;
         S_RUN:   if (count == CNT_LAST) state_next = S_WRITE;
         S_WRITE: state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Step counter and destination capture; count restarts on every accept.
   always_ff @(posedge clock) begin
      if (reset) begin
         count    <= '0;
         dest_reg <= '0;
      end else if (load) begin
         count    <= '0;
         dest_reg <= dest;
      end else if (step) begin
         count    <= count + CW'(1);
      end
   end

   // Remember the last written value/address so the write port holds steady.
   always_ff @(posedge clock) begin
      if (reset) begin
         result_hold <= '0;
         addr_hold   <= '0;
      end else if (state == S_WRITE) begin
         result_hold <= acc;
         addr_hold   <= dest_reg;
      end
   end

   // Output and datapath control decode from the current state.
   always_comb begin
      load       = 1'b0;
      step       = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      wb_write   = 1'b0;
      result     = result_hold;
      wb_address = addr_hold;
      case (state)
         S_IDLE: load = start;
         S_RUN: begin
            step = 1'b1;
            busy = 1'b1;
         end
         S_WRITE: begin
            busy       = 1'b1;
            done       = 1'b1;
            wb_write   = (dest_reg != ZR);
            result     = acc;
            wb_address = dest_reg;
         end
         default: ;
      endcase
   end

endmodule
